regfile_sb: RTL

//  Parametrised multi-read-port register file with write-to-read bypass and a per-register busy scoreboard.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 79 +++++++
 rtl/regfile_sb.sv | 74 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
//   RF_WIDTH_DEF  default data width
//   RF_NREG_DEF   default register count
//   RF_NRD_MAX    largest supported number of read ports
//   clog2()       address-width derivation usable in parameter expressions
package regfile_pkg;

  localparam int unsigned RF_WIDTH_DEF = 32;
  localparam int unsigned RF_NREG_DEF  = 32;
  localparam int unsigned RF_NRD_MAX   = 4;

  // Smallest res with 2**res >= n; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(n)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register file.
// Reservations are made at issue and cleared by the matching writeback; a reservation
// to a register that is still busy sets a sticky error. Per read port a RAW hazard is
// flagged when the addressed register is busy and the value is not being forwarded.
//   clk, reset          clock, asynchronous active-low reset
//   we, wa              writeback enable / address
//   rsv_en, rsv_addr    reserve request at issue
//   err_clr             synchronous clear of rsv_err
//   ra                  packed read addresses, port i at [i*AW +: AW]
//   busy                scoreboard vector (bit 0 always 0)
//   rsv_err             sticky reserve-while-busy flag
//   hz                  per-port hazard
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG   = RF_NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              err_clr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NREG-1:0]   busy,
  output logic              rsv_err,
  output logic [NRD-1:0]    hz
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            rsv_err_q, rsv_err_d;
  logic            rsv_set;

  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int unsigned r = 1; r < NREG; r++) begin
      // Reserve beats a same-cycle writeback: the new producer is still in flight.
      if (rsv_en && (rsv_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (we && (wa == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // A writeback retiring the old producer in the same cycle makes the re-reserve legal.
  always_comb begin
    rsv_set   = rsv_en && (rsv_addr != '0) && busy_q[rsv_addr] && !(we && (wa == rsv_addr));
    rsv_err_d = rsv_set | (rsv_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign busy    = busy_q;
  assign rsv_err = rsv_err_q;

  // Hazards look at the registered busy vector only, so a same-cycle reserve never flags.
  for (genvar i = 0; i < NRD; i++) begin : g_hz
    logic [AW-1:0] ra_i;
    logic          fwd;
    assign ra_i  = ra[i*AW +: AW];
    assign fwd   = (BYPASS != 0) && we && (wa == ra_i);
    assign hz[i] = (ra_i != '0) && busy_q[ra_i] && !fwd;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and busy scoreboard.
// Register 0 is hard-wired to zero, never written and never reserved.
//   clk, reset          clock, asynchronous active-low reset
//   we, wa, wd          writeback port (one-cycle latency to storage)
//   ra / rd             packed read addresses / data, port i at [i*AW] / [i*WIDTH]
//   hz                  per-port RAW hazard
//   rsv_en, rsv_addr    reserve destination at issue
//   busy                scoreboard vector
//   rsv_err, err_clr    sticky reserve-while-busy flag and its clear
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH  = RF_WIDTH_DEF,
  parameter int unsigned NREG   = RF_NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  output logic [NRD-1:0]       hz,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [NREG-1:0]      busy,
  output logic                 rsv_err,
  input  logic                 err_clr
);

  logic [WIDTH-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        rf_q[r] <= '0;
      end
    end else if (we && (wa != '0)) begin
      rf_q[wa] <= wd;
    end
  end

  // Forwarding is suppressed while reset is held so reads show the cleared file.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra_i;
    logic          fwd;
    assign ra_i = ra[i*AW +: AW];
    assign fwd  = (BYPASS != 0) && reset && we && (wa == ra_i);
    assign rd[i*WIDTH +: WIDTH] = (ra_i == '0) ? '0 : (fwd ? wd : rf_q[ra_i]);
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .err_clr  (err_clr),
    .ra       (ra),
    .busy     (busy),
    .rsv_err  (rsv_err),
    .hz       (hz)
  );

endmodule
